// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle for seq_multiplier. The slave modport is
// the multiplier side; the master modport is the operand source/result consumer.
interface seq_multiplier_if #(
   parameter int WIDTH = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   x;
   logic [WIDTH-1:0]   y;
   logic               signed_mode;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] o;
   logic               busy;

   modport slave (
      input  in_valid, x, y, signed_mode, out_ready,
      output in_ready, out_valid, o, busy
   );

   modport master (
      output in_valid, x, y, signed_mode, out_ready,
      input  in_ready, out_valid, o, busy
   );
endinterface

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: one partial-product add per clock over WIDTH cycles,
// signed operands handled by sign-magnitude conversion around an unsigned core.
module seq_multiplier #(
   parameter int WIDTH     = 8,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seq_multiplier_if.slave      mul_if
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [CW-1:0]      count_q;
   logic               neg_q;
   logic [2*WIDTH-1:0] o_q;
   logic               out_valid_q;

   logic               eff_signed;
   logic [WIDTH-1:0]   x_abs;
   logic [WIDTH-1:0]   y_abs;
   logic [2*WIDTH-1:0] acc_d;
   logic [2*WIDTH-1:0] res_d;

   // NOTE: every signal is given a value on all paths here so no latch is inferred.
   always_comb begin
      eff_signed = SIGNED_EN && mul_if.signed_mode;
      // -2^(W-1) negates to itself, which read as unsigned is its magnitude.
      x_abs      = (eff_signed && mul_if.x[WIDTH-1]) ? -mul_if.x : mul_if.x;
      y_abs      = (eff_signed && mul_if.y[WIDTH-1]) ? -mul_if.y : mul_if.y;
      acc_d      = acc_q + (mplier_q[0] ? mcand_q : '0);
      res_d      = neg_q ? -acc_d : acc_d;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         count_q     <= '0;
         neg_q       <= 1'b0;
         o_q         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mul_if.in_valid) begin
                  mcand_q  <= {{WIDTH{1'b0}}, x_abs};
                  mplier_q <= y_abs;
                  neg_q    <= eff_signed & (mul_if.x[WIDTH-1] ^ mul_if.y[WIDTH-1]);
                  acc_q    <= '0;
                  count_q  <= '0;
                  state_q  <= CALC;
               end
            end
            CALC: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               count_q  <= count_q + 1'b1;
               if (count_q == CW'(WIDTH - 1)) begin
                  o_q         <= res_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (mul_if.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mul_if.in_ready  = (state_q == IDLE);
   assign mul_if.busy      = (state_q != IDLE);
   assign mul_if.out_valid = out_valid_q;
   assign mul_if.o         = o_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: two instances (SIGNED_EN=1 and 0) run in lockstep
// on shared stimulus and are checked against an arithmetic reference model.
module tb_seq_multiplier;
   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] x;
   logic [7:0] y;
   logic       signed_mode;
   logic       out_ready;

   int checks = 0;
   int errors = 0;

   seq_multiplier_if #(.WIDTH(8)) bus0 ();
   seq_multiplier_if #(.WIDTH(8)) bus1 ();

   assign bus0.in_valid    = in_valid;
   assign bus0.x           = x;
   assign bus0.y           = y;
   assign bus0.signed_mode = signed_mode;
   assign bus0.out_ready   = out_ready;
   assign bus1.in_valid    = in_valid;
   assign bus1.x           = x;
   assign bus1.y           = y;
   assign bus1.signed_mode = signed_mode;
   assign bus1.out_ready   = out_ready;

   seq_multiplier #(.WIDTH(8), .SIGNED_EN(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .mul_if(bus0));
   seq_multiplier #(.WIDTH(8), .SIGNED_EN(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .mul_if(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   // Reference: the product of the operands read as integers, kept to 16 bits.
   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic sm, input bit en);
      int p;
      if (sm && en) p = int'($signed(a)) * int'($signed(b));
      else          p = int'(a) * int'(b);
      return p[15:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic sm);
      @(negedge clk);
      check("in_ready_before_accept", 32'(bus0.in_ready), 32'd1);
      x = a; y = b; signed_mode = sm; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x = 8'($urandom);
      y = 8'($urandom);
      signed_mode = 1'($urandom);
      check("busy_after_accept", 32'({bus0.busy, bus0.in_ready}), 32'b10);
   endtask

   task automatic wait_done(input string tag, input logic [15:0] exp0, input logic [15:0] exp1);
      int n = 0;
      while (bus0.out_valid !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'd8);
      check({tag, "_o_signed_en"}, 32'(bus0.o), 32'(exp0));
      check({tag, "_o_unsigned_only"}, 32'(bus1.o), 32'(exp1));
      check({tag, "_valid_unsigned_only"}, 32'(bus1.out_valid), 32'd1);
   endtask

   task automatic finish_op(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_handoff"}, 32'({bus0.out_valid, bus0.in_ready, bus0.busy}), 32'b010);
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rs;
      logic [15:0] held;

      rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; signed_mode = 1'b0; out_ready = 1'b1;
      #3;
      check("reset_state", 32'({bus0.in_ready, bus0.out_valid, bus0.busy}), 32'b100);
      check("reset_o", 32'(bus0.o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      start_op(8'd15, 8'd13, 1'b0);
      wait_done("u15x13", 16'h00C3, 16'h00C3);
      finish_op("u15x13");

      start_op(8'hFF, 8'hFF, 1'b0);
      wait_done("u255x255", 16'hFE01, 16'hFE01);
      finish_op("u255x255");

      start_op(8'h80, 8'h80, 1'b1);
      wait_done("s_m128x_m128", 16'h4000, 16'h4000);
      finish_op("s_m128x_m128");

      start_op(8'hFD, 8'h05, 1'b1);
      wait_done("s_m3x5", 16'hFFF1, 16'h04F1);
      finish_op("s_m3x5");

      start_op(8'h7F, 8'h80, 1'b1);
      wait_done("s_127x_m128", 16'hC080, 16'h3F80);
      finish_op("s_127x_m128");

      // Backpressure: result held while the consumer stalls, new operands ignored.
      out_ready = 1'b0;
      start_op(8'd21, 8'd11, 1'b0);
      wait_done("stall", 16'd231, 16'd231);
      held = bus0.o;
      @(negedge clk);
      x = 8'd9; y = 8'd9; signed_mode = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("stall_hold_flags", 32'({bus0.out_valid, bus0.in_ready, bus0.busy}), 32'b101);
         check("stall_hold_o", 32'(bus0.o), 32'(held));
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      finish_op("stall");
      start_op(8'd3, 8'd4, 1'b0);
      wait_done("after_stall", 16'd12, 16'd12);
      finish_op("after_stall");

      // Asynchronous reset in the middle of CALC.
      start_op(8'h55, 8'h33, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_flags", 32'({bus0.in_ready, bus0.out_valid, bus0.busy}), 32'b100);
      check("midreset_o", 32'(bus0.o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      start_op(8'd7, 8'd6, 1'b0);
      wait_done("u7x6", 16'h002A, 16'h002A);
      finish_op("u7x6");

      // signed_mode is honoured only by the SIGNED_EN=1 instance.
      start_op(8'hFF, 8'h02, 1'b1);
      wait_done("ff_x2_signed_mode", 16'hFFFE, 16'h01FE);
      finish_op("ff_x2_signed_mode");

      for (int k = 0; k < 16; k++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 1'($urandom);
         start_op(ra, rb, rs);
         wait_done($sformatf("rand%0d", k), model(ra, rb, rs, 1'b1), model(ra, rb, rs, 1'b0));
         finish_op($sformatf("rand%0d", k));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
